// File: rtl/vga_rect_device_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared types and constants for the rectangle VGA device.
//   rect_t        one rectangle: position, size (10-bit each) and RGB colour
//   REG_*         byte addresses of the 16-entry register window
//   total_len()   sum of the four timing segments of one axis
// -----------------------------------------------------------------------------
package vga_pkg;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] w;
        logic [9:0] h;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rect_t;

    localparam logic [3:0] REG_CTRL = 4'h0;
    localparam logic [3:0] REG_SEL  = 4'h1;
    localparam logic [3:0] REG_XL   = 4'h2;
    localparam logic [3:0] REG_XH   = 4'h3;
    localparam logic [3:0] REG_YL   = 4'h4;
    localparam logic [3:0] REG_YH   = 4'h5;
    localparam logic [3:0] REG_WL   = 4'h6;
    localparam logic [3:0] REG_WH   = 4'h7;
    localparam logic [3:0] REG_HL   = 4'h8;
    localparam logic [3:0] REG_HH   = 4'h9;
    localparam logic [3:0] REG_R    = 4'hA;
    localparam logic [3:0] REG_G    = 4'hB;
    localparam logic [3:0] REG_B    = 4'hC;
    localparam logic [3:0] REG_BGR  = 4'hD;
    localparam logic [3:0] REG_BGG  = 4'hE;
    localparam logic [3:0] REG_BGB  = 4'hF;

    function automatic int total_len(input int active, input int fp,
                                     input int sync_len, input int bp);
        return active + fp + sync_len + bp;
    endfunction

endpackage

// File: rtl/vga_rect_device_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Pixel-enable divider plus horizontal/vertical raster counters.
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   o_pe              one-cycle pixel enable, every CLK_DIV clocks (first on
//                     the first edge after reset release)
//   o_x, o_y          current raster position (counter values)
//   o_hsync_n/o_vsync_n  combinational sync levels for the current position
//   o_active          position lies inside the visible area
//   o_in_vblank       y is in the vertical blanking region
//   o_vblank_start    pe at x=0, y=V_ACTIVE (frame-end commit point)
//   o_frame_tick      pe on the last pixel of the frame (y about to wrap)
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic       o_pe,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_hsync_n,
    output logic       o_vsync_n,
    output logic       o_active,
    output logic       o_in_vblank,
    output logic       o_vblank_start,
    output logic       o_frame_tick
);

    localparam int H_TOTAL = total_len(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total_len(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    logic             w_pe;
    logic             w_x_last;
    logic             w_y_last;

    // pe fires while the divider sits at 0, so the very first edge after
    // reset release is already a pixel edge.
    assign w_pe     = (r_div == '0);
    assign w_x_last = (r_x == H_LAST);
    assign w_y_last = (r_y == V_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div <= '0;
        end else if (r_div == DIV_MAX) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_pe) begin
            if (w_x_last) begin
                r_x <= '0;
                r_y <= w_y_last ? 10'd0 : r_y + 10'd1;
            end else begin
                r_x <= r_x + 10'd1;
            end
        end
    end

    assign o_pe           = w_pe;
    assign o_x            = r_x;
    assign o_y            = r_y;
    assign o_hsync_n      = !((r_x >= HS_START) && (r_x < HS_END));
    assign o_vsync_n      = !((r_y >= VS_START) && (r_y < VS_END));
    assign o_active       = (r_x < H_ACT_C) && (r_y < V_ACT_C);
    assign o_in_vblank    = (r_y >= V_ACT_C);
    assign o_vblank_start = w_pe && (r_x == 10'd0) && (r_y == V_ACT_C);
    assign o_frame_tick   = w_pe && w_x_last && w_y_last;

endmodule

// File: rtl/vga_rect_device.sv
// -----------------------------------------------------------------------------
// vga_rect_device
// Bus-mapped VGA controller drawing up to RECTS solid rectangles over a
// background colour. CPU writes go to shadow registers; a commit request is
// applied at the start of vertical blanking so a frame never shows a
// half-updated rectangle set.
//   clk, rst_n                 clock, asynchronous active-low reset
//   address/enable/mode/data_in  bus access (mode 1 = write), sampled on clk
//   data_out                   registered read data (holds between reads)
//   red/green/blue             pixel colour, 0 outside active video
//   hsync/vsync                active-low syncs, aligned with colour
//   blank                      1 during active video
//   sync                       constant 0
// -----------------------------------------------------------------------------
module vga_rect_device
    import vga_pkg::*;
#(
    parameter int RECTS    = 4,
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] address,
    input  logic       enable,
    input  logic       mode,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       hsync,
    output logic       vsync,
    output logic       blank,
    output logic       sync
);

    localparam int SEL_W = (RECTS > 1) ? $clog2(RECTS) : 1;

    logic             w_pe;
    logic [9:0]       w_x;
    logic [9:0]       w_y;
    logic             w_hsync_n;
    logic             w_vsync_n;
    logic             w_active;
    logic             w_in_vblank;
    logic             w_vblank_start;
    logic             w_frame_tick;

    rect_t            r_shadow [RECTS];
    rect_t            r_live   [RECTS];
    logic [23:0]      r_bg_shadow;
    logic [23:0]      r_bg_live;
    logic [SEL_W-1:0] r_sel;
    logic             r_display_en;
    logic             r_commit_pend;
    logic [7:0]       r_frame_cnt;
    logic [7:0]       r_data_out;
    logic [7:0]       r_red;
    logic [7:0]       r_green;
    logic [7:0]       r_blue;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_blank;

    logic             w_wr;
    logic             w_rd;
    logic             w_commit_now;
    logic [SEL_W-1:0] w_sel_wrapped;
    logic [7:0]       w_rd_data;
    logic [23:0]      w_pix_rgb;
    logic [10:0]      w_x11;
    logic [10:0]      w_y11;
    rect_t            w_sel_rect;

    vga_timing_gen #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .o_pe           (w_pe),
        .o_x            (w_x),
        .o_y            (w_y),
        .o_hsync_n      (w_hsync_n),
        .o_vsync_n      (w_vsync_n),
        .o_active       (w_active),
        .o_in_vblank    (w_in_vblank),
        .o_vblank_start (w_vblank_start),
        .o_frame_tick   (w_frame_tick)
    );

    assign w_wr          = enable && mode;
    assign w_rd          = enable && !mode;
    assign w_commit_now  = w_vblank_start && r_commit_pend;
    assign w_sel_wrapped = SEL_W'(int'(data_in) % RECTS);
    assign w_sel_rect    = r_shadow[r_sel];

    // Register bank and commit. The live copy takes the shadow contents from
    // before any write in the same cycle; a CTRL commit write in the commit
    // cycle wins over the clear, leaving the request pending for next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RECTS; i++) begin
                r_shadow[i] <= '0;
                r_live[i]   <= '0;
            end
            r_bg_shadow   <= '0;
            r_bg_live     <= '0;
            r_sel         <= '0;
            r_display_en  <= 1'b0;
            r_commit_pend <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            if (w_commit_now) begin
                for (int i = 0; i < RECTS; i++) begin
                    r_live[i] <= r_shadow[i];
                end
                r_bg_live     <= r_bg_shadow;
                r_commit_pend <= 1'b0;
            end
            if (w_frame_tick) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            if (w_wr) begin
                case (address)
                    REG_CTRL: begin
                        r_display_en <= data_in[0];
                        if (data_in[1]) begin
                            r_commit_pend <= 1'b1;
                        end
                    end
                    REG_SEL: r_sel                  <= w_sel_wrapped;
                    REG_XL:  r_shadow[r_sel].x[7:0] <= data_in;
                    REG_XH:  r_shadow[r_sel].x[9:8] <= data_in[1:0];
                    REG_YL:  r_shadow[r_sel].y[7:0] <= data_in;
                    REG_YH:  r_shadow[r_sel].y[9:8] <= data_in[1:0];
                    REG_WL:  r_shadow[r_sel].w[7:0] <= data_in;
                    REG_WH:  r_shadow[r_sel].w[9:8] <= data_in[1:0];
                    REG_HL:  r_shadow[r_sel].h[7:0] <= data_in;
                    REG_HH:  r_shadow[r_sel].h[9:8] <= data_in[1:0];
                    REG_R:   r_shadow[r_sel].r      <= data_in;
                    REG_G:   r_shadow[r_sel].g      <= data_in;
                    REG_B:   r_shadow[r_sel].b      <= data_in;
                    REG_BGR: r_bg_shadow[23:16]     <= data_in;
                    REG_BGG: r_bg_shadow[15:8]      <= data_in;
                    REG_BGB: r_bg_shadow[7:0]       <= data_in;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_rd_data = 8'h00;
        case (address)
            REG_CTRL: w_rd_data = {r_frame_cnt[5:0], r_commit_pend, w_in_vblank};
            REG_SEL:  w_rd_data = 8'(r_sel);
            REG_XL:   w_rd_data = w_sel_rect.x[7:0];
            REG_XH:   w_rd_data = {6'd0, w_sel_rect.x[9:8]};
            REG_YL:   w_rd_data = w_sel_rect.y[7:0];
            REG_YH:   w_rd_data = {6'd0, w_sel_rect.y[9:8]};
            REG_WL:   w_rd_data = w_sel_rect.w[7:0];
            REG_WH:   w_rd_data = {6'd0, w_sel_rect.w[9:8]};
            REG_HL:   w_rd_data = w_sel_rect.h[7:0];
            REG_HH:   w_rd_data = {6'd0, w_sel_rect.h[9:8]};
            REG_R:    w_rd_data = w_sel_rect.r;
            REG_G:    w_rd_data = w_sel_rect.g;
            REG_B:    w_rd_data = w_sel_rect.b;
            REG_BGR:  w_rd_data = r_bg_shadow[23:16];
            REG_BGG:  w_rd_data = r_bg_shadow[15:8];
            REG_BGB:  w_rd_data = r_bg_shadow[7:0];
            default:  w_rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out <= '0;
        end else if (w_rd) begin
            r_data_out <= w_rd_data;
        end
    end

    // Priority mux: scanning from the highest index down lets the lowest
    // index overwrite last. End coordinates use 11 bits so X+W never wraps.
    assign w_x11 = {1'b0, w_x};
    assign w_y11 = {1'b0, w_y};

    always_comb begin
        w_pix_rgb = r_bg_live;
        for (int i = RECTS - 1; i >= 0; i--) begin
            if ((r_live[i].w != 10'd0) && (r_live[i].h != 10'd0) &&
                (w_x11 >= {1'b0, r_live[i].x}) &&
                (w_x11 < ({1'b0, r_live[i].x} + {1'b0, r_live[i].w})) &&
                (w_y11 >= {1'b0, r_live[i].y}) &&
                (w_y11 < ({1'b0, r_live[i].y} + {1'b0, r_live[i].h}))) begin
                w_pix_rgb = {r_live[i].r, r_live[i].g, r_live[i].b};
            end
        end
    end

    // Colour and syncs share one register stage so they stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_blank <= 1'b0;
        end else if (w_pe) begin
            if (!w_active) begin
                {r_red, r_green, r_blue} <= 24'h000000;
            end else if (!r_display_en) begin
                {r_red, r_green, r_blue} <= r_bg_live;
            end else begin
                {r_red, r_green, r_blue} <= w_pix_rgb;
            end
            r_hsync <= w_hsync_n;
            r_vsync <= w_vsync_n;
            r_blank <= w_active;
        end
    end

    assign data_out = r_data_out;
    assign red      = r_red;
    assign green    = r_green;
    assign blue     = r_blue;
    assign hsync    = r_hsync;
    assign vsync    = r_vsync;
    assign blank    = r_blank;
    assign sync     = 1'b0;

endmodule

// File: tb/tb_vga_rect_device.sv
// -----------------------------------------------------------------------------
// tb_vga_rect_device
// Drives the rectangle VGA device with a reduced raster so many frames fit in
// a short run. A transaction-level model tracks raster position from the edge
// count since reset release, the shadow/live register sets and the commit
// request, and queues the expected pixel and read responses.
// -----------------------------------------------------------------------------
module tb_vga_rect_device;

    localparam int RECTS     = 4;
    localparam int CLK_DIV   = 2;
    localparam int H_ACTIVE  = 32;
    localparam int H_FP      = 2;
    localparam int H_SYNC    = 4;
    localparam int H_BP      = 2;
    localparam int V_ACTIVE  = 20;
    localparam int V_FP      = 2;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 2;
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME_PIX = H_TOTAL * V_TOTAL;
    localparam int FRAME_CLK = FRAME_PIX * CLK_DIV;
    localparam logic [23:0] BG = 24'h102030;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] address = 4'h0;
    logic       enable = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic [7:0] red, green, blue;
    logic       hsync, vsync, blank, sync;

    vga_rect_device #(
        .RECTS(RECTS), .CLK_DIV(CLK_DIV),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .enable(enable),
        .mode(mode), .data_in(data_in), .data_out(data_out),
        .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync),
        .blank(blank), .sync(sync)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- counters / scoreboard ----------------
    int total = 0;
    int bad = 0;
    int edge_n = -1;
    logic [31:0] px_q[$];
    int          pos_q[$];
    logic [31:0] rd_q[$];
    logic [23:0] obs [V_ACTIVE][H_ACTIVE];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int sh [RECTS][7];   // fields: 0 x, 1 y, 2 w, 3 h, 4 r, 5 g, 6 b
    int lv [RECTS][7];
    int bg_sh [3];
    int bg_lv [3];
    int m_sel, m_den, m_pend;

    task automatic model_reset();
        for (int i = 0; i < RECTS; i++)
            for (int f = 0; f < 7; f++) begin
                sh[i][f] = 0;
                lv[i][f] = 0;
            end
        for (int c = 0; c < 3; c++) begin
            bg_sh[c] = 0;
            bg_lv[c] = 0;
        end
        m_sel = 0;
        m_den = 0;
        m_pend = 0;
    endtask

    function automatic logic [31:0] pixel_model(input int x, input int y);
        int act, hs, vs, col, found;
        act = (x < H_ACTIVE && y < V_ACTIVE) ? 1 : 0;
        hs = (x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC) ? 0 : 1;
        vs = (y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC) ? 0 : 1;
        col = 0;
        if (act != 0) begin
            col = (bg_lv[0] << 16) | (bg_lv[1] << 8) | bg_lv[2];
            found = 0;
            if (m_den != 0)
                for (int i = 0; i < RECTS; i++)
                    if (found == 0 && lv[i][2] != 0 && lv[i][3] != 0 &&
                        x >= lv[i][0] && x < lv[i][0] + lv[i][2] &&
                        y >= lv[i][1] && y < lv[i][1] + lv[i][3]) begin
                        found = 1;
                        col = (lv[i][4] << 16) | (lv[i][5] << 8) | lv[i][6];
                    end
        end
        return {4'd0, 1'b0, col[23:0], hs[0], vs[0], act[0]};
    endfunction

    function automatic logic [31:0] read_model(input int a, input int y, input int frm);
        int v;
        v = 0;
        if (a == 0) v = ((frm % 64) << 2) | (m_pend << 1) | ((y >= V_ACTIVE) ? 1 : 0);
        else if (a == 1) v = m_sel;
        else if (a <= 9) begin
            if ((a - 2) % 2 == 0) v = sh[m_sel][(a - 2) / 2] & 'hFF;
            else v = (sh[m_sel][(a - 2) / 2] >> 8) & 3;
        end
        else if (a <= 12) v = sh[m_sel][4 + a - 10];
        else v = bg_sh[a - 13];
        return v;
    endfunction

    task automatic write_model(input int a, input int d);
        int f;
        if (a == 0) begin
            m_den = d & 1;
            if ((d & 2) != 0) m_pend = 1;
        end
        else if (a == 1) m_sel = d % RECTS;
        else if (a <= 9) begin
            f = (a - 2) / 2;
            if ((a - 2) % 2 == 0) sh[m_sel][f] = (sh[m_sel][f] & 'h300) | d;
            else sh[m_sel][f] = (sh[m_sel][f] & 'hFF) | ((d & 3) << 8);
        end
        else if (a <= 12) sh[m_sel][4 + a - 10] = d;
        else bg_sh[a - 13] = d;
    endtask

    initial begin
        int pix, x, y, frm;
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                model_reset();
                edge_n = -1;
            end else begin
                edge_n++;
                pix = (edge_n + CLK_DIV - 1) / CLK_DIV;
                x = pix % H_TOTAL;
                y = (pix / H_TOTAL) % V_TOTAL;
                frm = pix / FRAME_PIX;
                if (enable && !mode) rd_q.push_back(read_model(int'(address), y, frm));
                if (edge_n % CLK_DIV == 0) begin
                    px_q.push_back(pixel_model(x, y));
                    pos_q.push_back(y * 1024 + x);
                    if (x == 0 && y == V_ACTIVE && m_pend != 0) begin
                        for (int i = 0; i < RECTS; i++)
                            for (int f = 0; f < 7; f++) lv[i][f] = sh[i][f];
                        for (int c = 0; c < 3; c++) bg_lv[c] = bg_sh[c];
                        m_pend = 0;
                    end
                end
                if (enable && mode) write_model(int'(address), int'(data_in));
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [31:0] exp_w, act_w;
        int p;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                px_q.delete();
                pos_q.delete();
                rd_q.delete();
            end else begin
                if (px_q.size() > 0) begin
                    exp_w = px_q.pop_front();
                    p = pos_q.pop_front();
                    act_w = {4'd0, sync, red, green, blue, hsync, vsync, blank};
                    check("pixel", act_w, exp_w);
                    if ((p % 1024) < H_ACTIVE && (p / 1024) < V_ACTIVE)
                        obs[p / 1024][p % 1024] = {red, green, blue};
                end
                if (rd_q.size() > 0) begin
                    exp_w = rd_q.pop_front();
                    check("read", {24'd0, data_out}, exp_w);
                end
            end
        end
    end

    // Sync-edge recorder for the first frame after release.
    logic rec_en = 1'b0;
    int h_fall0 = -1, h_fall1 = -1, v_fall = -1, v_rise = -1;
    initial begin
        logic ph, pv;
        ph = 1'b1;
        pv = 1'b1;
        forever begin
            @(negedge clk);
            if (rec_en) begin
                if (ph && !hsync) begin
                    if (h_fall0 < 0) h_fall0 = edge_n;
                    else if (h_fall1 < 0) h_fall1 = edge_n;
                end
                if (pv && !vsync && v_fall < 0) v_fall = edge_n;
                if (!pv && vsync && v_rise < 0) v_rise = edge_n;
            end
            ph = hsync;
            pv = vsync;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic bw(input logic [3:0] a, input logic [7:0] d);
        address = a; data_in = d; mode = 1'b1; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0; mode = 1'b0;
    endtask

    task automatic br(input logic [3:0] a, output logic [7:0] v);
        address = a; mode = 1'b0; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        v = data_out;
    endtask

    task automatic wait_frames(input int n);
        repeat (n * FRAME_CLK) @(negedge clk);
    endtask

    task automatic write_rect(input int sel, input int x, input int y, input int w,
                              input int h, input logic [23:0] rgb);
        bw(4'h1, 8'(sel));
        bw(4'h2, 8'(x));      bw(4'h3, 8'(x >> 8));
        bw(4'h4, 8'(y));      bw(4'h5, 8'(y >> 8));
        bw(4'h6, 8'(w));      bw(4'h7, 8'(w >> 8));
        bw(4'h8, 8'(h));      bw(4'h9, 8'(h >> 8));
        bw(4'hA, rgb[23:16]); bw(4'hB, rgb[15:8]); bw(4'hC, rgb[7:0]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rgb"},   {8'd0, red, green, blue}, 32'd0);
        check({tag, "_hsync"}, {31'd0, hsync}, 32'd1);
        check({tag, "_vsync"}, {31'd0, vsync}, 32'd1);
        check({tag, "_blank"}, {31'd0, blank}, 32'd0);
        check({tag, "_sync"},  {31'd0, sync}, 32'd0);
        check({tag, "_dout"},  {24'd0, data_out}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] v;
        int guard;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        rec_en = 1'b1;

        // Raster timing of the first frame.
        br(4'h0, v);
        check("status_at_start", {24'd0, v}, 32'd0);
        wait_frames(1);
        repeat (10) @(negedge clk);
        rec_en = 1'b0;
        check("hsync_first_fall", h_fall0, CLK_DIV * (H_ACTIVE + H_FP));
        check("hsync_period", h_fall1 - h_fall0, CLK_DIV * H_TOTAL);
        check("vsync_fall", v_fall, CLK_DIV * H_TOTAL * (V_ACTIVE + V_FP));
        check("vsync_width", v_rise - v_fall, CLK_DIV * H_TOTAL * V_SYNC);

        // Single rectangle over a background, then commit.
        bw(4'hD, BG[23:16]); bw(4'hE, BG[15:8]); bw(4'hF, BG[7:0]);
        write_rect(0, 10, 5, 4, 3, 24'hFF0000);
        bw(4'h0, 8'h03);
        br(4'h2, v);
        check("rd_xl", {24'd0, v}, 32'd10);
        wait_frames(2);
        check("r0_origin", {8'd0, obs[5][10]}, {8'd0, 24'hFF0000});
        check("r0_last",   {8'd0, obs[7][13]}, {8'd0, 24'hFF0000});
        check("r0_right",  {8'd0, obs[5][14]}, {8'd0, BG});
        check("r0_left",   {8'd0, obs[5][9]},  {8'd0, BG});
        check("r0_below",  {8'd0, obs[8][10]}, {8'd0, BG});

        // Overlap: rect0 has priority; removing it reveals rect1.
        write_rect(1, 12, 6, 6, 4, 24'h00FF00);
        bw(4'h0, 8'h03);
        wait_frames(2);
        check("overlap_r0", {8'd0, obs[6][12]}, {8'd0, 24'hFF0000});
        check("only_r1",    {8'd0, obs[6][17]}, {8'd0, 24'h00FF00});
        check("r1_low",     {8'd0, obs[9][12]}, {8'd0, 24'h00FF00});
        bw(4'h1, 8'd0);
        bw(4'h6, 8'd0);
        bw(4'h0, 8'h03);
        wait_frames(2);
        check("r1_revealed", {8'd0, obs[6][12]}, {8'd0, 24'h00FF00});

        // Uncommitted shadow write stays invisible.
        bw(4'h1, 8'd1);
        bw(4'h2, 8'd0);
        br(4'h0, v);
        check("pend_idle", {31'd0, v[1]}, 32'd0);
        wait_frames(3);
        check("no_commit_old", {8'd0, obs[6][12]}, {8'd0, 24'h00FF00});
        check("no_commit_new", {8'd0, obs[6][2]},  {8'd0, BG});
        bw(4'h0, 8'h03);
        br(4'h0, v);
        check("pend_set", {31'd0, v[1]}, 32'd1);
        wait_frames(1);
        br(4'h0, v);
        check("pend_cleared", {31'd0, v[1]}, 32'd0);
        wait_frames(1);
        check("commit_moved", {8'd0, obs[6][2]}, {8'd0, 24'h00FF00});

        // Commit request landing exactly on the commit cycle stays pending.
        bw(4'h0, 8'h03);
        guard = 0;
        while (((edge_n + 1) % (CLK_DIV * FRAME_PIX)) != CLK_DIV * V_ACTIVE * H_TOTAL &&
               guard < 2 * FRAME_CLK) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2 * FRAME_CLK) begin
            total++;
            bad++;
            $display("FAIL commit_edge_search: waited %0d clocks, limit %0d", guard, 2 * FRAME_CLK);
        end
        bw(4'h0, 8'h03);
        br(4'h0, v);
        check("pend_kept", {31'd0, v[1]}, 32'd1);
        wait_frames(1);
        br(4'h0, v);
        check("pend_next_frame", {31'd0, v[1]}, 32'd0);

        // Clipped rectangle: X=1020,W=20 must not wrap onto x=0.
        write_rect(2, 1020, 0, 20, 20, 24'h0000FF);
        bw(4'h0, 8'h03);
        wait_frames(2);
        check("clip_x0",  {8'd0, obs[0][0]},  {8'd0, BG});
        check("clip_x15", {8'd0, obs[0][15]}, {8'd0, BG});

        // SEL wraps modulo RECTS.
        bw(4'h1, 8'(RECTS + 1));
        bw(4'hA, 8'h77);
        br(4'h1, v);
        check("sel_wrap", {24'd0, v}, 32'd1);
        bw(4'h1, 8'd1);
        br(4'hA, v);
        check("sel_wrap_data", {24'd0, v}, 32'h77);

        // Display disabled: active area shows background.
        bw(4'h0, 8'h00);
        wait_frames(2);
        check("den_off", {8'd0, obs[6][2]}, {8'd0, BG});
        bw(4'h0, 8'h01);
        repeat ($urandom_range(200, 900)) @(negedge clk);

        // Asynchronous reset mid-frame.
        br(4'hA, v);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        br(4'h0, v);
        check("status_after_reset", {24'd0, v}, 32'd0);
        br(4'h2, v);
        check("shadow_after_reset", {24'd0, v}, 32'd0);
        wait_frames(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
